conv_div_seq: RTL and testbench

//  Sequential unsigned radix-2 restoring divider; inverse of the conv-core 8x14 multiplier.

---
 rtl/conv_div_pkg.sv | 13 +
 rtl/conv_div_step.sv | 22 ++
 rtl/conv_div_seq.sv | 101 ++++++++++
 tb/tb_conv_div_seq.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_div_pkg.sv
// Shared widths and state encoding for the conv-core sequential divider.
package conv_div_pkg;
  localparam int DIVIDEND_W = 22;
  localparam int DIVISOR_W  = 8;
  localparam int QUOT_W     = 14;
  localparam int CNT_W      = $clog2(DIVIDEND_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/conv_div_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract the divisor if it fits.
module conv_div_step
  import conv_div_pkg::*;
(
  input  logic [DIVISOR_W:0]   prem,
  input  logic                 dbit,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   prem_next,
  output logic                 qbit
);
  logic [DIVISOR_W:0] shifted;
  // The partial remainder is always below the divisor, so its top bit is zero on entry.
  logic               unused_msb;

  assign unused_msb = prem[DIVISOR_W];

  always_comb begin
    shifted   = {prem[DIVISOR_W-1:0], dbit};
    qbit      = (shifted >= {1'b0, divisor});
    prem_next = qbit ? (shifted - {1'b0, divisor}) : shifted;
  end
endmodule

// File: rtl/conv_div_seq.sv
// Sequential radix-2 restoring divider recovering the 14-bit operand from a 22-bit product.
module conv_div_seq
  import conv_div_pkg::*;
(
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [QUOT_W-1:0]     quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  ovf,
  output logic                  dz
);
  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic                  dz_r;
  // Dividend bits leave at the MSB while quotient bits enter at the LSB.
  logic [DIVIDEND_W-1:0] dq_r;
  logic [DIVISOR_W:0]    prem_r;
  logic [DIVISOR_W-1:0]  dvs_r;
  logic [DIVISOR_W:0]    prem_nxt;
  logic                  qbit;
  logic                  accept;

  function automatic logic [QUOT_W:0] saturate(input logic [DIVIDEND_W-1:0] q);
    if (|q[DIVIDEND_W-1:QUOT_W]) return {1'b1, {QUOT_W{1'b1}}};
    return {1'b0, q[QUOT_W-1:0]};
  endfunction

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;

  conv_div_step u_step (
    .prem      (prem_r),
    .dbit      (dq_r[DIVIDEND_W-1]),
    .divisor   (dvs_r),
    .prem_next (prem_nxt),
    .qbit      (qbit)
  );

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      dz_r      <= 1'b0;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
      dz        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dz_r  <= (divisor == '0);
            cnt   <= CNT_W'(DIVIDEND_W - 1);
            state <= (divisor == '0) ? DONE : CALC;
          end
        end
        CALC: begin
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= DONE;
        end
        DONE: begin
          // Results are registered on the first DONE cycle and then held until taken.
          if (!out_valid) begin
            out_valid <= 1'b1;
            remainder <= prem_r[DIVISOR_W-1:0];
            dz        <= dz_r;
            if (dz_r) begin
              quotient <= '1;
              ovf      <= 1'b0;
            end else begin
              {ovf, quotient} <= saturate(dq_r);
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath
  always_ff @(posedge ap_clk) begin
    if (accept) begin
      dq_r   <= dividend;
      dvs_r  <= divisor;
      prem_r <= (divisor == '0) ? {1'b0, dividend[DIVISOR_W-1:0]} : '0;
    end else if (state == CALC) begin
      dq_r   <= {dq_r[DIVIDEND_W-2:0], qbit};
      prem_r <= prem_nxt;
    end
  end
endmodule

// File: tb/tb_conv_div_seq.sv
// Directed and randomized checks of conv_div_seq against an arithmetic divide model.
module tb_conv_div_seq;
  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [21:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [13:0] quotient;
  logic [7:0]  remainder;
  logic        ovf;
  logic        dz;

  int n_assert = 0;
  int n_fail   = 0;

  conv_div_seq dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .ovf       (ovf),
    .dz        (dz)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division, saturation and divide-by-zero rules.
  task automatic model(input logic [21:0] a, input logic [7:0] b,
                       output logic [13:0] q, output logic [7:0] r,
                       output logic o, output logic z);
    int unsigned ai, bi, qf;
    ai = a;
    bi = b;
    if (bi == 0) begin
      q = 14'h3FFF; r = a[7:0]; o = 1'b0; z = 1'b1;
    end else begin
      qf = ai / bi;
      r  = 8'(ai % bi);
      o  = (qf >= 16384);
      q  = o ? 14'h3FFF : 14'(qf);
      z  = 1'b0;
    end
  endtask

  task automatic start(input logic [21:0] a, input logic [7:0] b);
    for (int i = 0; i < 100 && !in_ready; i++) begin
      @(posedge ap_clk); #1;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge ap_clk); #1;
      lat++;
    end
    if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic check_result(input string tag, input logic [21:0] a, input logic [7:0] b);
    logic [13:0] q;
    logic [7:0]  r;
    logic        o, z;
    model(a, b, q, r, o, z);
    check({tag, "_quot"}, 32'(quotient), 32'(q));
    check({tag, "_rem"},  32'(remainder), 32'(r));
    check({tag, "_ovf"},  32'(ovf), 32'(o));
    check({tag, "_dz"},   32'(dz), 32'(z));
  endtask

  task automatic take_result(input string tag);
    out_ready = 1'b1;
    @(posedge ap_clk); #1;
    out_ready = 1'b0;
    check({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_ir_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int          lat;
    logic [13:0] hq;
    logic [7:0]  hr;
    logic [21:0] ra;
    logic [7:0]  rb;
    int          sel;

    #1 ap_rst = 1'b1;
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_quot", 32'(quotient), 32'd0);
    check("rst_rem", 32'(remainder), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_dz", 32'(dz), 32'd0);
    @(posedge ap_clk); @(posedge ap_clk); #2;
    ap_rst = 1'b0;
    @(posedge ap_clk); #1;

    start(22'd4177665, 8'd255);
    wait_done(lat);
    check("t1_latency", 32'(lat), 32'd23);
    check("t1_quot_const", 32'(quotient), 32'd16383);
    check_result("t1", 22'd4177665, 8'd255);
    take_result("t1");

    start(22'd1000, 8'd7);
    wait_done(lat);
    check("t2a_quot_const", 32'(quotient), 32'd142);
    check("t2a_rem_const", 32'(remainder), 32'd6);
    take_result("t2a");
    start(22'd5, 8'd9);
    wait_done(lat);
    check_result("t2b", 22'd5, 8'd9);
    take_result("t2b");

    start(22'd1234, 8'd0);
    wait_done(lat);
    check("t3_latency", 32'(lat), 32'd1);
    check("t3_rem_const", 32'(remainder), 32'd210);
    check_result("t3", 22'd1234, 8'd0);
    take_result("t3");

    start(22'd4194303, 8'd1);
    wait_done(lat);
    check("t4_ovf_const", 32'(ovf), 32'd1);
    check_result("t4", 22'd4194303, 8'd1);
    take_result("t4");

    start(22'd0, 8'd13);
    wait_done(lat);
    check_result("zero_dvd", 22'd0, 8'd13);
    take_result("zero_dvd");

    // Backpressure, with stray in_valid pulses while busy.
    start(22'd1000, 8'd7);
    repeat (5) begin @(posedge ap_clk); #1; end
    check("t5_busy_ir", 32'(in_ready), 32'd0);
    in_valid = 1'b1; dividend = 22'd99; divisor = 8'd3;
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    wait_done(lat);
    check("t5_latency", 32'(lat), 32'd17);
    hq = quotient;
    hr = remainder;
    check_result("t5", 22'd1000, 8'd7);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; dividend = 22'd77; divisor = 8'd2;
      @(posedge ap_clk); #1;
      in_valid = 1'b0;
      check("t5_hold_ov", 32'(out_valid), 32'd1);
      check("t5_hold_q", 32'(quotient), 32'(hq));
      check("t5_hold_r", 32'(remainder), 32'(hr));
    end
    take_result("t5");
    @(posedge ap_clk); #1;
    check("t5_no_capture", 32'(in_ready), 32'd1);

    // Asynchronous reset in the middle of the iteration.
    start(22'd1000, 8'd7);
    repeat (10) begin @(posedge ap_clk); #1; end
    #2 ap_rst = 1'b1;
    #1;
    check("t6_ir", 32'(in_ready), 32'd1);
    check("t6_ov", 32'(out_valid), 32'd0);
    check("t6_q", 32'(quotient), 32'd0);
    #2 ap_rst = 1'b0;
    @(posedge ap_clk); #1;
    start(22'd1000, 8'd7);
    wait_done(lat);
    check("t6_latency", 32'(lat), 32'd23);
    check_result("t6", 22'd1000, 8'd7);
    take_result("t6");

    for (int n = 0; n < 1500; n++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0:       rb = 8'd0;
        1:       rb = 8'd1;
        2:       rb = 8'd255;
        default: rb = 8'($urandom);
      endcase
      if ($urandom_range(0, 3) == 0) ra = 22'($urandom_range(0, 300));
      else                           ra = 22'($urandom);
      start(ra, rb);
      wait_done(lat);
      check("rnd_latency", 32'(lat), (rb == 8'd0) ? 32'd1 : 32'd23);
      check_result("rnd", ra, rb);
      out_ready = 1'b1;
      @(posedge ap_clk); #1;
      out_ready = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
